// File: rtl/mul_hilo_capture.sv
// mul_hilo_capture: sequencer for an external multi-cycle multiplier with HI/LO
// result registers.
//
// A start request latches the operands, pulses mul_clr and waits for the
// multiplier to settle. It then captures the 64-bit product into HI/LO and
// pulses done.
//
// Ports:
//   clk, clr        clock and synchronous active-high reset
//   start           begin a multiply; ignored while busy
//   a_in, b_in      operands from the register file
//   product_in      product from the multiplier, sampled only on the capture edge
//   a_out, b_out    operands held stable to the multiplier
//   mul_clr         one-cycle pulse that clears the multiplier accumulator
//   busy, done      status flag and one-cycle completion pulse
//   bus_in, hi_wr,
//   lo_wr           direct HI/LO writes; dropped on the capture edge
//   hi_out, lo_out  HI/LO contents
//   ovf             product does not fit in 32 signed bits
//                   (present only when MUL_OVF_FLAG_EN is defined)
//
// Optional feature macro: MUL_OVF_FLAG_EN

module mul_hilo_capture #(
    parameter int unsigned LATENCY = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [63:0] product_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        mul_clr,
    output logic        busy,
    output logic        done,
    input  logic [31:0] bus_in,
    input  logic        hi_wr,
    input  logic        lo_wr,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic        ovf
`endif
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Sequencer, operand/result registers and status outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            a_out   <= '0;
            b_out   <= '0;
            hi_out  <= '0;
            lo_out  <= '0;
            mul_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MUL_OVF_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else begin
            mul_clr <= 1'b0;
            done    <= 1'b0;

            // Direct writes lose to the product capture.
            if (hi_wr && (state != CAPTURE)) hi_out <= bus_in;
            if (lo_wr && (state != CAPTURE)) lo_out <= bus_in;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_out   <= a_in;
                        b_out   <= b_in;
                        mul_clr <= 1'b1;
                        cnt     <= CNT_W'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end

                RUN: begin
                    // The cycle in which mul_clr is high is the clear cycle.
                    // The LATENCY count starts after it.
                    if (!mul_clr) begin
                        if (cnt == '0) begin
                            state <= CAPTURE;
                        end else begin
                            cnt   <= cnt - CNT_W'(1);
                        end
                    end
                end

                CAPTURE: begin
                    hi_out <= product_in[63:32];
                    lo_out <= product_in[31:0];
`ifdef MUL_OVF_FLAG_EN
                    ovf    <= (product_in[63:32] != {32{product_in[31]}});
`endif
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_hilo_capture.sv
module tb_mul_hilo_capture;

    localparam int unsigned LATENCY = 16;
    localparam int unsigned DONE_EDGE = LATENCY + 2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] a_in, b_in;
    logic [63:0] product_in;
    logic [31:0] a_out, b_out;
    logic        mul_clr, busy, done;
    logic [31:0] bus_in;
    logic        hi_wr, lo_wr;
    logic [31:0] hi_out, lo_out;
`ifdef MUL_OVF_FLAG_EN
    logic        ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    int   t0;
    int   seen;
    exp_t sb[$];

    mul_hilo_capture #(.LATENCY(LATENCY)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .product_in (product_in),
        .a_out      (a_out),
        .b_out      (b_out),
        .mul_clr    (mul_clr),
        .busy       (busy),
        .done       (done),
        .bus_in     (bus_in),
        .hi_wr      (hi_wr),
        .lo_wr      (lo_wr),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
`ifdef MUL_OVF_FLAG_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: garbage until LATENCY cycles after the clear pulse.
    logic [7:0]  lat_cnt = 8'd255;
    logic [63:0] prod_full;
    always @(posedge clk) begin
        if (mul_clr) lat_cnt <= 8'd0;
        else if (lat_cnt != 8'd255) lat_cnt <= lat_cnt + 8'd1;
    end
    assign prod_full  = {{32{a_out[31]}}, a_out} * {{32{b_out[31]}}, b_out};
    assign product_in = (lat_cnt >= 8'(LATENCY)) ? prod_full : 64'hBAD0_BAD0_BAD0_BAD0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t e;
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.hi  = p[63:32];
        e.lo  = p[31:0];
        e.ovf = (p[63:32] != {32{p[31]}});
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past one posedge and settle at the following negedge.
    task automatic tick();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
    endtask

    // Accept a start at the next edge, which becomes edge 0 of the operation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
        t0 = edge_no;
        sb.push_back(model(a, b));
        chk("mul_clr_pulse", 64'(mul_clr), 64'd1);
        chk("busy_run", 64'(busy), 64'd1);
        chk("a_out_latch", 64'(a_out), 64'(a));
        chk("b_out_latch", 64'(b_out), 64'(b));
    endtask

    // Wait for done, bounded, and compare the result against the scoreboard head.
    task automatic wait_done(input string tag, input int exp_edge);
        exp_t e;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) begin seen = 1; break; end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen == 1) begin
            chk({tag, "_done_edge"}, 64'(edge_no - t0), 64'(exp_edge));
            e = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi_out), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo_out), 64'(e.lo));
`ifdef MUL_OVF_FLAG_EN
            chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
`endif
            chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        bus_in = 32'h1234_5678; hi_wr = 1'b1; lo_wr = 1'b1;
        tick();
        tick();
        // Reset overrides direct writes.
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mul_clr", 64'(mul_clr), 64'd0);
        chk("rst_a_out", 64'(a_out), 64'd0);
`ifdef MUL_OVF_FLAG_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        clr = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        tick();

        // Basic multiply: 3 * 5.
        issue(32'd3, 32'd5);
        tick();
        chk("mul_clr_one_cycle", 64'(mul_clr), 64'd0);
        wait_done("op_3x5", DONE_EDGE);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        // Negative times positive.
        issue(32'hFFFF_FFFE, 32'd3);
        wait_done("op_neg", DONE_EDGE);
        tick();

        // Overflowing product.
        issue(32'h0001_0000, 32'h0001_0000);
        wait_done("op_ovf", DONE_EDGE);
        tick();
`ifdef MUL_OVF_FLAG_EN
        hi_wr = 1'b1; lo_wr = 1'b1; bus_in = 32'h0000_0001;
        tick();
        hi_wr = 1'b0; lo_wr = 1'b0;
        chk("ovf_hold_on_write", 64'(ovf), 64'd1);
`endif

        // Starts while busy are ignored; start held in DONE chains an op.
        issue(32'd7, 32'd9);
        while (edge_no < t0 + 2) tick();
        a_in = 32'h5555_5555; b_in = 32'hAAAA_AAAA; start = 1'b1;
        tick();
        start = 1'b0;
        while (edge_no < t0 + 9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_a_out", 64'(a_out), 64'd7);
        chk("ignore_b_out", 64'(b_out), 64'd9);
        wait_done("op_ignore", DONE_EDGE);
        a_in = 32'd11; b_in = 32'hFFFF_FFF3; start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(model(32'd11, 32'hFFFF_FFF3));
        chk("chain_a_out", 64'(a_out), 64'd11);
        chk("chain_busy", 64'(busy), 64'd1);
        wait_done("op_chain", 2 * DONE_EDGE + 1);
        tick();

        // Clear in the middle of RUN aborts the operation.
        a_in = 32'd4; b_in = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        t0 = edge_no;
        while (edge_no < t0 + 7) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi_out), 64'd0);
        chk("abort_lo", 64'(lo_out), 64'd0);
        chk("abort_a_out", 64'(a_out), 64'd0);
        chk("abort_b_out", 64'(b_out), 64'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // Direct HI write on the capture edge loses to the product.
        issue(32'd3, 32'd5);
        while (edge_no < t0 + DONE_EDGE - 1) tick();
        hi_wr = 1'b1; bus_in = 32'hDEAD_BEEF;
        tick();
        hi_wr = 1'b0;
        chk("cap_wr_done", 64'(done), 64'd1);
        if (done) begin
            exp_t e;
            e = sb.pop_front();
            chk("cap_wr_hi", 64'(hi_out), 64'(e.hi));
            chk("cap_wr_lo", 64'(lo_out), 64'(e.lo));
        end
        tick();
        hi_wr = 1'b1; bus_in = 32'hDEAD_BEEF;
        tick();
        hi_wr = 1'b0;
        chk("idle_wr_hi", 64'(hi_out), 64'hDEAD_BEEF);
        chk("idle_wr_lo_kept", 64'(lo_out), 64'h0000_000F);
        lo_wr = 1'b1; bus_in = 32'hCAFE_F00D;
        tick();
        lo_wr = 1'b0;
        chk("idle_wr_lo", 64'(lo_out), 64'hCAFE_F00D);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_hilo_capture.md
MUL_HILO_CAPTURE -- requirements
Module: mul_hilo_capture

Interface
REQ-001 SHALL have parameter: LATENCY, 16, number of clk cycles the multiplier needs after mul_clr before product_in is valid (legal range 1-255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a multiply.
REQ-005 SHALL have ports: a_in, b_in  input  32 each  multiplicand and multiplier from the register file.
REQ-006 SHALL have port: product_in  input  64  product from the Booth multiplier.
REQ-007 SHALL have ports: a_out, b_out  output  32 each  operands held stable to the multiplier.
REQ-008 SHALL have port: mul_clr  output  1  one-cycle pulse clearing the multiplier accumulator.
REQ-009 SHALL have ports: busy, done  output  1 each  status and completion pulse.
REQ-010 SHALL have ports: bus_in  input  32, hi_wr  input  1, lo_wr  input  1  direct HI/LO writes.
REQ-011 SHALL have ports: hi_out, lo_out  output  32 each  HI and LO register contents.
REQ-012 SHALL have port: ovf  output  1  product does not fit in 32 signed bits (present only per REQ-027).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, CAPTURE, DONE.
REQ-014 IDLE or DONE with start=1: latch a_in/b_in into a_out/b_out, pulse mul_clr for that cycle, load counter with LATENCY-1, go to RUN.
REQ-015 RUN: decrement counter each cycle; at counter=0 go to CAPTURE.
REQ-016 CAPTURE: write hi_out=product_in[63:32] and lo_out=product_in[31:0]; go to DONE.
REQ-017 DONE: done=1 for exactly one cycle; go to IDLE unless start=1 (REQ-014 applies, back-to-back accepted).
REQ-018 Latency: hi_out/lo_out update, and done rises, on edge LATENCY+2 counted from the edge sampling start (edge 0).
REQ-019 busy SHALL be 1 in RUN and CAPTURE, 0 in IDLE and DONE.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands, counter or outputs.
REQ-021 a_out/b_out SHALL hold their values from the start edge until the next accepted start.
REQ-022 hi_wr/lo_wr SHALL load bus_in into HI/LO on the edge, in any state except CAPTURE.
REQ-023 hi_wr/lo_wr coinciding with the CAPTURE edge SHALL be dropped; the capture wins.
REQ-024 product_in SHALL be sampled only on the CAPTURE edge and ignored in other cycles.

Reset
REQ-025 clr=1 at a posedge SHALL force: state IDLE, counter 0, a_out, b_out, hi_out and lo_out 0, mul_clr, busy, done and ovf 0; clr SHALL override start, hi_wr and lo_wr.
REQ-026 clr asserted mid-RUN SHALL abort the operation: no capture, no done pulse.

Configuration
REQ-027 With macro MUL_OVF_FLAG_EN defined: port ovf SHALL exist; on CAPTURE it SHALL be set to 1 iff product_in[63:32] != {32{product_in[31]}}; it SHALL hold its value until the next CAPTURE or clr; hi_wr/lo_wr SHALL NOT change it.
REQ-028 Without MUL_OVF_FLAG_EN: port ovf and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-029 Test, with LATENCY=16 and a behavioural product model: a_in=3, b_in=5, start pulse -> mul_clr pulse at edge 0; done at edge 18; hi_out=0x00000000; lo_out=0x0000000F; ovf=0.
REQ-030 Test: a_in=0xFFFFFFFE, b_in=3 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA, ovf=0.
REQ-031 Test: a_in=0x00010000, b_in=0x00010000 -> hi_out=0x00000001, lo_out=0x00000000, ovf=1 (macro defined); with the macro undefined the port is absent.
REQ-032 Test: start re-asserted at edges 3 and 10 -> ignored; a_out/b_out unchanged; single done at edge 18; start held in DONE -> second op done at edge 37.
REQ-033 Test: clr at edge 8 of RUN -> busy=0 and all outputs 0 next cycle; no done pulse for the following 20 cycles.
REQ-034 Test: hi_wr=1 with bus_in=0xDEADBEEF on the CAPTURE edge -> hi_out equals the product high word; the same write in IDLE -> hi_out=0xDEADBEEF.
